// File: rtl/fifo_rr_sched_pkg.sv
// fifo_rr_sched_pkg
//   Shared types and width helpers for the round-robin fifo read scheduler.
//   - state_t     : scheduler FSM encoding
//   - grant_w()   : width of a port index, never less than 1 bit
//   - burst_cnt_w(): width of a counter that can hold 0..BURST
package fifo_rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LOAD = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    function automatic int grant_w(input int n_ports);
        return (n_ports > 2) ? $clog2(n_ports) : 1;
    endfunction

    function automatic int burst_cnt_w(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/fifo_rr_sched_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first requesting port
//   after 'last', wrapping modulo N_PORTS.
//   Ports:
//     req   [N_PORTS]  request per port (bit i = port i)
//     last  [GRANT_W]  most recently served port
//     grant [GRANT_W]  chosen port (0 when nothing requests)
//     any              at least one request present
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int GRANT_W = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] grant,
    output logic               any
);

    logic [2*N_PORTS-1:0] req_dbl;
    logic                 found;

    // Doubling the request vector turns the wrap-around search into a
    // linear scan of the window (last, last+N_PORTS].
    always_comb begin
        req_dbl = {req, req};
        grant   = '0;
        found   = 1'b0;
        for (int k = 0; k < 2*N_PORTS; k++) begin
            if (!found && req_dbl[k] && (k > int'(last)) && (k <= int'(last) + N_PORTS)) begin
                found = 1'b1;
                grant = GRANT_W'(k % N_PORTS);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched
//   Drains N_PORTS fifos into one registered valid/ready stream, serving a
//   granted port for up to BURST words before rotating round-robin.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     fifo_empty    per-fifo empty flag
//     fifo_dout     per-fifo registered read data, port i at [i*D_SIZE +: D_SIZE]
//     fifo_rd_en    per-fifo pop strobe, one-hot or zero
//     m_data/m_src  output word and its source port
//     m_valid/m_ready output handshake
//     busy          scheduler not in IDLE
//   Build option: FIFO_RR_SCHED_PRIO0_EN gives port 0 strict priority.
//
//   state | meaning
//   IDLE  | waiting for any non-empty fifo; picks the next grant
//   READ  | pop strobe to the granted fifo
//   LOAD  | fifo d_out valid; capture into the output register
//   SEND  | hold output until accepted; continue burst or release grant
module fifo_rr_sched
    import fifo_rr_sched_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int D_SIZE  = 32,
    parameter int BURST   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            fifo_empty,
    input  logic [N_PORTS*D_SIZE-1:0]     fifo_dout,
    output logic [N_PORTS-1:0]            fifo_rd_en,
    output logic [D_SIZE-1:0]             m_data,
    output logic [grant_w(N_PORTS)-1:0]   m_src,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          busy
);

    localparam int GRANT_W = grant_w(N_PORTS);
    localparam int CNT_W   = burst_cnt_w(BURST);
    localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(BURST);
    localparam logic [GRANT_W-1:0] LAST_RST  = GRANT_W'(N_PORTS - 1);

    state_t               state_q,   state_d;
    logic [GRANT_W-1:0]   grant_q,   grant_d;
    logic [GRANT_W-1:0]   last_q,    last_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [D_SIZE-1:0]    m_data_q,  m_data_d;
    logic [GRANT_W-1:0]   m_src_q,   m_src_d;
    logic                 m_valid_q, m_valid_d;

    logic [N_PORTS-1:0]   req;
    logic [GRANT_W-1:0]   pick;
    logic                 pick_any;
    logic                 prio_hit;
    logic                 preempt;
    logic                 upd_last;

`ifdef FIFO_RR_SCHED_PRIO0_EN
    // Port 0 bypasses the rotation entirely, so it is hidden from the picker
    // and never recorded as last grant; ports 1..N-1 keep their own order.
    assign req      = ~fifo_empty & ~N_PORTS'(1);
    assign prio_hit = ~fifo_empty[0];
    assign preempt  = prio_hit && (grant_q != '0);
    assign upd_last = (grant_q != '0);
`else
    assign req      = ~fifo_empty;
    assign prio_hit = 1'b0;
    assign preempt  = 1'b0;
    assign upd_last = 1'b1;
`endif

    rr_pick #(
        .N_PORTS (N_PORTS),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .grant (pick),
        .any   (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_src_d   = m_src_q;
        m_valid_d = m_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (prio_hit) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = ST_READ;
                end else if (pick_any) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                m_data_d  = fifo_dout[int'(grant_q)*D_SIZE +: D_SIZE];
                m_src_d   = grant_q;
                m_valid_d = 1'b1;
                if (cnt_q < BURST_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // The pop was two cycles ago, so fifo_empty already reflects it.
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    if ((cnt_q < BURST_MAX) && !fifo_empty[grant_q] && !preempt) begin
                        state_d = ST_READ;
                    end else begin
                        if (upd_last) begin
                            last_d = grant_q;
                        end
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= LAST_RST;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_src_q   <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_src_q   <= m_src_d;
            m_valid_q <= m_valid_d;
        end
    end

    always_comb begin
        fifo_rd_en = '0;
        if (state_q == ST_READ) begin
            fifo_rd_en[grant_q] = 1'b1;
        end
    end

    assign m_data  = m_data_q;
    assign m_src   = m_src_q;
    assign m_valid = m_valid_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/fifo_rr_sched.md
Name: fifo_rr_sched

Overview:
- Round-robin read scheduler that drains N_PORTS independent fifo instances into one registered output stream with valid/ready handshake.
- Sits between a bank of fifos and a single consumer, such as a host/PCIe egress or a shared compute core.
- Owns every fifo rd_en. Uses each fifo's f_empty flag and its 1-cycle registered d_out.
- Grants a port for a burst of up to BURST words, then rotates to the next port.

Parameters:
- N_PORTS, 4: number of fifos served; 2..16.
- D_SIZE, 32: data width; must equal the fifo D_SIZE.
- BURST, 4: max words popped per grant; 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- fifo_empty  in  N_PORTS  f_empty of each fifo; bit i = port i.
- fifo_dout  in  N_PORTS*D_SIZE  d_out of each fifo; port i occupies bits [i*D_SIZE +: D_SIZE].
- fifo_rd_en  out  N_PORTS  rd_en to each fifo; one-hot or zero.
- m_data  out  D_SIZE  output word.
- m_src  out  GRANT_W  index of the port that supplied m_data; GRANT_W = max(1, clog2(N_PORTS)).
- m_valid  out  1  m_data/m_src valid.
- m_ready  in  1  consumer accepts when m_valid && m_ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state = IDLE, fifo_rd_en = 0, m_valid = 0, m_data = 0, m_src = 0, busy = 0, burst counter = 0, last_grant = N_PORTS-1 (so port 0 wins first).
- FSM states: IDLE, READ, LOAD, SEND.
- IDLE:
  - If any fifo_empty bit is 0, pick the first non-empty port searching last_grant+1, last_grant+2, ... with modulo N_PORTS wrap.
  - Register the pick as grant, clear the burst counter, go to READ.
  - Otherwise stay in IDLE.
- READ:
  - fifo_rd_en[grant] = 1 for exactly this one cycle; go to LOAD.
  - READ is entered only when fifo_empty[grant] was 0 in the previous cycle, so the pop is always legal.
- LOAD:
  - fifo_dout[grant] is valid this cycle.
  - Register m_data <= fifo_dout[grant], m_src <= grant, m_valid <= 1; increment the burst counter; go to SEND.
- SEND:
  - Hold m_valid, m_data and m_src stable until m_ready.
  - On handshake: m_valid <= 0.
  - If burst counter < BURST and fifo_empty[grant] == 0, go to READ on the same port.
  - Else last_grant <= grant, go to IDLE.
  - m_ready while m_valid is low is ignored.
- Latency: non-empty seen in IDLE at cycle t -> rd_en at t+1 -> m_valid at t+3.
- Peak rate: 1 word per 3 cycles within a burst (SEND->READ->LOAD->SEND).
- Burst ends early if the granted fifo runs empty. fifo_empty in SEND is valid because the pop happened 2 cycles earlier.
- BURST = 1 gives pure word-level round-robin. The burst counter is clog2(BURST+1) bits wide and saturates at BURST.
- Single non-empty port: it is re-granted after passing through IDLE. The empty-port rotation adds no extra cycles.
- Reset mid-operation: state returns to IDLE immediately. A word popped but not yet handed off is discarded; this is documented data loss.
- fifo_rd_en is never asserted in IDLE, LOAD or SEND, and never on more than one bit at a time.

Optional Feature:
- FIFO_RR_SCHED_PRIO0_EN defined: port 0 has strict priority.
  - In IDLE, port 0 wins whenever fifo_empty[0] == 0.
  - In SEND, a burst on another port ends at the handshake if fifo_empty[0] == 0.
  - last_grant is not updated by port-0 grants, so the round-robin order of ports 1..N-1 is preserved.
- Not defined: pure round-robin as specified above; port 0 has no special treatment.

Decomposition:
- Package fifo_rr_sched_pkg holds:
  - the state encoding (IDLE = 2'd0, READ = 2'd1, LOAD = 2'd2, SEND = 2'd3);
  - the GRANT_W calculation function;
  - the burst-counter width function.
- Sub-module rr_pick: combinational round-robin picker with inputs req[N_PORTS] and last[GRANT_W], outputs grant[GRANT_W] and any.
  - Implemented as a double-width mask search.
  - Reused for the priority variant by masking req.

Test Plan:
- Reset then all fifos empty for 20 cycles -> fifo_rd_en = 0, m_valid = 0, busy = 0 throughout.
- N_PORTS=4, BURST=2; fifos 0..3 each preloaded with 3 words (0xA0+i*16+k) and m_ready tied high -> m_src order 0,0,1,1,2,2,3,3,0,1,2,3 with matching data; m_valid is first seen 3 cycles after leaving IDLE.
- Only port 2 holds 5 words, BURST=4 -> 4 words from port 2, one IDLE cycle, then the 5th word; no rd_en ever on ports 0, 1, 3.
- m_ready held low for 10 cycles during SEND -> m_data and m_src stable, no further rd_en; on release, exactly one handshake and then READ.
- Reset asserted asynchronously in LOAD with port 1 granted -> outputs clear in the same cycle without a clock edge; after release, port 0 is granted first if non-empty.
- FIFO_RR_SCHED_PRIO0_EN defined, port 3 mid-burst (BURST=4) and port 0 becomes non-empty -> port 3 burst ends after the current word, the next m_src is 0, and the ports 1..3 round-robin resumes at port 1.
